// File: rtl/instr_fetch.sv
// RV32 instruction-fetch stage with IF/ID pipeline register and req/ack imem handshake.
// Optional performance counters are compiled in with `define IFETCH_PERF_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
`ifdef IFETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_wait_cnt,
`endif
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] req_addr, req_addr_n;
    logic [31:0] hold_buf, hold_buf_n;
    logic        if_valid_n;
    logic [31:0] if_pc_n, if_instruction_n;
    logic        load;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign imem_req         = (state == FETCH) || (state == DROP);
    assign imem_addr        = req_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            req_addr       <= RESET_PC;
            hold_buf       <= 32'h0;
            if_valid       <= 1'b0;
            if_pc          <= 32'h0;
            if_instruction <= NOP;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            req_addr       <= req_addr_n;
            hold_buf       <= hold_buf_n;
            if_valid       <= if_valid_n;
            if_pc          <= if_pc_n;
            if_instruction <= if_instruction_n;
        end
    end

    // Redirect outranks stall; a request already on the bus is finished in DROP, never withdrawn.
    always_comb begin
        state_n          = state;
        pc_n             = pc;
        req_addr_n       = req_addr;
        hold_buf_n       = hold_buf;
        if_valid_n       = if_valid;
        if_pc_n          = if_pc;
        if_instruction_n = if_instruction;
        load             = 1'b0;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (redirect) begin
                    if_valid_n = 1'b0;
                    pc_n       = redirect_aligned;
                    if (imem_ack) req_addr_n = redirect_aligned;
                    else          state_n    = DROP;
                end else if (imem_ack) begin
                    if (!stall) begin
                        load             = 1'b1;
                        if_pc_n          = req_addr;
                        if_instruction_n = imem_rdata;
                        pc_n             = req_addr + 32'd4;
                        req_addr_n       = req_addr + 32'd4;
                    end else begin
                        hold_buf_n = imem_rdata;
                        state_n    = HOLD;
                    end
                end else if (!stall) begin
                    if_valid_n = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    if_valid_n = 1'b0;
                    pc_n       = redirect_aligned;
                    req_addr_n = redirect_aligned;
                    state_n    = FETCH;
                end else if (!stall) begin
                    load             = 1'b1;
                    if_pc_n          = pc;
                    if_instruction_n = hold_buf;
                    pc_n             = pc + 32'd4;
                    req_addr_n       = pc + 32'd4;
                    state_n          = FETCH;
                end
            end
            DROP: begin
                if (redirect) begin
                    if_valid_n = 1'b0;
                    pc_n       = redirect_aligned;
                end
                if (imem_ack) begin
                    req_addr_n = redirect ? redirect_aligned : pc;
                    state_n    = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) if_valid_n = 1'b1;
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 32'h0;
            perf_wait_cnt  <= 32'h0;
        end else begin
            if (load)                  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (imem_req && !imem_ack) perf_wait_cnt  <= perf_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table with an instruction scoreboard,
// plus a hand-written reset-during-wait sequence.
module tb_instr_fetch;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] XKEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    instr_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
`ifdef IFETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_wait_cnt(perf_wait_cnt),
`endif
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_instruction(if_instruction)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic        push;
        logic        pop;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    vec_t        vecs[$];
    item_t       sb[$];
    int          checks = 0;
    int          fails = 0;
    logic [31:0] last_pc = 32'h0;
    logic [31:0] last_instr = NOP;

    function automatic vec_t mk(logic st, logic rd, logic [31:0] rp, logic ak,
                                logic rq, logic [31:0] ad, logic vl, logic pu, logic po);
        vec_t v;
        v.stall = st; v.redirect = rd; v.rpc = rp; v.ack = ak;
        v.exp_req = rq; v.exp_addr = ad; v.exp_valid = vl; v.push = pu; v.pop = po;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        item_t it;
        @(negedge clk);
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        imem_ack    = v.ack;
        imem_rdata  = v.exp_addr ^ XKEY;
        checkOutput($sformatf("step%0d imem_req", idx), {31'h0, imem_req}, {31'h0, v.exp_req});
        checkOutput($sformatf("step%0d imem_addr", idx), imem_addr, v.exp_addr);
        if (v.push) begin
            it.pc = v.exp_addr;
            it.instr = v.exp_addr ^ XKEY;
            sb.push_back(it);
        end
        @(posedge clk);
        #1;
        checkOutput($sformatf("step%0d if_valid", idx), {31'h0, if_valid}, {31'h0, v.exp_valid});
        if (v.pop) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL step%0d scoreboard: got empty queue expected an entry", idx);
            end else begin
                it = sb.pop_front();
                last_pc = it.pc;
                last_instr = it.instr;
            end
        end
        checkOutput($sformatf("step%0d if_pc", idx), if_pc, last_pc);
        checkOutput($sformatf("step%0d if_instruction", idx), if_instruction, last_instr);
    endtask

    initial begin
        // stall redirect rpc ack | req addr valid push pop
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h100,      0, 0, 0)); // IDLE
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h100,      1, 1, 1)); // zero-wait stream
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h104,      1, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h108,      1, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h10C,      0, 0, 0)); // wait states
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h10C,      0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h10C,      1, 1, 1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h110,      1, 1, 0)); // ack under stall
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h110,      1, 0, 0)); // HOLD
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h110,      1, 0, 1)); // release buffer
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h114,      1, 1, 1));
        vecs.push_back(mk(0, 1, 32'h203,      0, 1, 32'h118,      0, 0, 0)); // redirect pending
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h118,      0, 0, 0)); // DROP
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h118,      0, 0, 0)); // dropped data
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h200,      1, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h204,      0, 0, 0));
        vecs.push_back(mk(1, 1, 32'h300,      1, 1, 32'h204,      0, 0, 0)); // redirect+stall
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h300,      1, 1, 1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h304,      1, 0, 0)); // to HOLD
        vecs.push_back(mk(1, 1, 32'h400,      0, 0, 32'h304,      0, 0, 0)); // redirect from HOLD
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h400,      1, 1, 1));
        vecs.push_back(mk(0, 1, 32'h500,      0, 1, 32'h404,      0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h600,      0, 1, 32'h404,      0, 0, 0)); // redirect in DROP
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h404,      0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h600,      1, 1, 1));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFE, 1, 1, 32'h604,      0, 0, 0)); // align to top word
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hFFFFFFFC, 1, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0,        1, 1, 1)); // wrapped
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h4,        0, 0, 0)); // pending at reset

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset imem_req", {31'h0, imem_req}, 32'h0);
        checkOutput("reset imem_addr", imem_addr, RPC);
        checkOutput("reset if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("reset if_pc", if_pc, 32'h0);
        checkOutput("reset if_instruction", if_instruction, NOP);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);
        checkOutput("scoreboard drained", sb.size(), 32'h0);

        // Reset while 0x4 is still outstanding, then a late ack that must be ignored.
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst mid imem_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst mid imem_addr", imem_addr, RPC);
        checkOutput("rst mid if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("rst mid if_pc", if_pc, 32'h0);
        checkOutput("rst mid if_instruction", if_instruction, NOP);
`ifdef IFETCH_PERF_EN
        checkOutput("rst perf_fetch_cnt", perf_fetch_cnt, 32'h0);
        checkOutput("rst perf_wait_cnt", perf_wait_cnt, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        checkOutput("late ack imem_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("late ack if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("late ack if_instruction", if_instruction, NOP);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = RPC ^ XKEY;
        checkOutput("restart imem_req", {31'h0, imem_req}, 32'h1);
        checkOutput("restart imem_addr", imem_addr, RPC);
        @(posedge clk);
        #1;
        checkOutput("restart if_valid", {31'h0, if_valid}, 32'h1);
        checkOutput("restart if_pc", if_pc, RPC);
        checkOutput("restart if_instruction", if_instruction, RPC ^ XKEY);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
